// File: rtl/lsu_stage.sv
// lsu_stage: multi-cycle load/store stage sitting between execute and
// writeback. Accepts one instruction at a time. For memory instructions it
// performs a single transaction on a single-outstanding SRAM-style bus.
// Non-memory instructions are passed through with their address/ALU result.
//
// Ports:
//   clk, rst_n          - clock; synchronous active-high reset (asserted = 1)
//   prev_valid/this_ready  - upstream handshake (this_ready only in IDLE)
//   this_valid/next_ready  - downstream handshake (this_valid only in DONE)
//   mem_req, mem_wen, funct3, addr, wdata - instruction fields from execute
//   result, is_load, access_err           - completed instruction outcome
//   bus_req_valid/bus_req_ready, bus_addr, bus_wen, bus_wdata, bus_wstrb
//                                          - bus request channel
//   bus_rsp_valid/bus_rsp_ready, bus_rdata - bus response channel
module lsu_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prev_valid,
    output logic              this_ready,
    input  logic              next_ready,
    output logic              this_valid,
    input  logic              mem_req,
    input  logic              mem_wen,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] result,
    output logic              is_load,
    output logic              access_err,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_wen,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic              bus_rsp_valid,
    output logic              bus_rsp_ready,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic              req_q, wen_q, err_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] result_q;
    logic              in_err;
    logic [1:0]        off;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [DATA_W-1:0] load_data;

    assign off = addr_q[1:0];

    // Decode illegal size/sign encodings and misalignment on the incoming
    // instruction, so a bad access never reaches the bus.
    always_comb begin
        in_err = 1'b0;
        if (mem_req) begin
            case (funct3)
                3'b001, 3'b101:         in_err = addr[0];
                3'b010:                 in_err = (addr[1:0] != 2'b00);
                3'b011, 3'b110, 3'b111: in_err = 1'b1;
                default:                in_err = 1'b0;
            endcase
            // Stores only exist for byte/half/word (000..010).
            if (mem_wen && funct3[2]) in_err = 1'b1;
        end
    end

    // Next-state logic for the IDLE -> REQ -> WAIT -> DONE sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (prev_valid) state_d = (!mem_req || in_err) ? DONE : REQ;
            REQ:  if (bus_req_ready) state_d = WAIT;
            WAIT: if (bus_rsp_valid) state_d = DONE;
            DONE: if (next_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Select the addressed byte/half lane of the returned word and extend it.
    always_comb begin
        lane_b    = bus_rdata[{off, 3'b000} +: 8];
        lane_h    = bus_rdata[{off[1], 4'b0000} +: 16];
        load_data = bus_rdata;
        case (f3_q)
            3'b000:  load_data = {{(DATA_W-8){lane_b[7]}}, lane_b};
            3'b100:  load_data = {{(DATA_W-8){1'b0}}, lane_b};
            3'b001:  load_data = {{(DATA_W-16){lane_h[15]}}, lane_h};
            3'b101:  load_data = {{(DATA_W-16){1'b0}}, lane_h};
            default: load_data = bus_rdata;
        endcase
    end

    // Store lane steering: the data is replicated across all lanes so the
    // strobe alone picks the bytes that get written. Loads write nothing.
    always_comb begin
        bus_wstrb = 4'b0000;
        bus_wdata = '0;
        if (req_q && wen_q) begin
            case (f3_q[1:0])
                2'b00: begin
                    bus_wstrb = 4'b0001 << off;
                    bus_wdata = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    bus_wstrb = 4'b0011 << off;
                    bus_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    bus_wstrb = 4'b1111;
                    bus_wdata = wdata_q;
                end
            endcase
        end
    end

    // State register plus instruction capture. result starts as the captured
    // address and is overwritten only when a load response arrives.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            wen_q    <= 1'b0;
            err_q    <= 1'b0;
            f3_q     <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && prev_valid) begin
                req_q    <= mem_req;
                wen_q    <= mem_wen;
                err_q    <= in_err;
                f3_q     <= funct3;
                addr_q   <= addr;
                wdata_q  <= wdata;
                result_q <= addr;
            end
            if (state_q == WAIT && bus_rsp_valid && !wen_q) begin
                result_q <= load_data;
            end
        end
    end

    assign this_ready    = (state_q == IDLE);
    assign this_valid    = (state_q == DONE);
    assign bus_req_valid = (state_q == REQ);
    assign bus_rsp_ready = (state_q == WAIT);
    assign bus_addr      = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus_wen       = req_q & wen_q;
    assign result        = result_q;
    assign access_err    = err_q;
    assign is_load       = req_q & ~wen_q & ~err_q;

endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: scoreboard bench for lsu_stage. Directed instructions push
// their expected results and bus requests into queues; independent monitors
// pop and compare whenever the DUT completes an instruction or a bus request
// handshakes. A small bus slave model provides configurable stalls.
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        prev_valid = 1'b0;
    logic        this_ready;
    logic        next_ready;
    logic        this_valid;
    logic        mem_req = 1'b0;
    logic        mem_wen = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] result;
    logic        is_load;
    logic        access_err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_wen;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rsp_valid;
    logic        bus_rsp_ready;
    logic [31:0] bus_rdata;

    lsu_stage #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .prev_valid(prev_valid), .this_ready(this_ready),
        .next_ready(next_ready), .this_valid(this_valid),
        .mem_req(mem_req), .mem_wen(mem_wen), .funct3(funct3),
        .addr(addr), .wdata(wdata),
        .result(result), .is_load(is_load), .access_err(access_err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_ready(bus_rsp_ready),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        ld;
        logic        err;
        int          lat;
        int          acc_cyc;
    } res_exp_t;

    typedef struct {
        logic [31:0] baddr;
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] wd;
    } bus_exp_t;

    res_exp_t res_q[$];
    bus_exp_t bus_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int          req_cnt = 0;
    int          rsp_delay = 0;
    int          rsp_cnt = 0;
    int          nr_cnt = 0;
    bit          pending = 1'b0;
    logic [31:0] hs_addr = 32'h0;
    logic        hs_wen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Bus slave and downstream model, driven 1 time unit after each edge.
    initial begin
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rdata     = 32'h0;
        next_ready    = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                bus_req_ready = 1'b0;
                bus_rsp_valid = 1'b0;
                bus_rdata     = 32'h0;
                pending       = 1'b0;
                rsp_cnt       = 0;
                req_cnt       = 0;
                nr_cnt        = 0;
                next_ready    = 1'b1;
            end else begin
                if (bus_rsp_valid) begin
                    bus_rsp_valid = 1'b0;
                    bus_rdata     = 32'h0;
                end
                if (bus_req_ready) begin
                    bus_req_ready = 1'b0;
                    pending       = 1'b1;
                    rsp_cnt       = rsp_delay;
                    hs_addr       = bus_addr;
                    hs_wen        = bus_wen;
                end else if (bus_req_valid && !pending) begin
                    if (req_cnt > 0) req_cnt--;
                    else bus_req_ready = 1'b1;
                end
                if (pending) begin
                    if (rsp_cnt > 0) rsp_cnt--;
                    else begin
                        bus_rsp_valid = 1'b1;
                        pending       = 1'b0;
                        bus_rdata     = hs_wen ? 32'hDEAD_BEEF :
                                        (hs_addr == 32'h100 ? 32'h8070_F0FF : 32'h0);
                    end
                end
                if (this_valid && nr_cnt > 0) begin
                    next_ready = 1'b0;
                    nr_cnt--;
                end else begin
                    next_ready = 1'b1;
                end
            end
        end
    end

    // Bus request monitor: request fields must hold while stalled, and each
    // handshake must match the next expected request.
    initial begin
        bus_exp_t    be;
        logic        pv = 1'b0;
        logic        pr = 1'b0;
        logic [31:0] pa = 32'h0;
        logic [31:0] pw = 32'h0;
        logic [3:0]  ps = 4'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (pv && !pr && bus_req_valid) begin
                    checkOutput("req_addr_stable", bus_addr, pa);
                    checkOutput("req_wstrb_stable", {28'h0, bus_wstrb}, {28'h0, ps});
                    checkOutput("req_wdata_stable", bus_wdata, pw);
                end
                if (bus_req_valid && bus_req_ready) begin
                    if (bus_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL bus_unexpected_req: got request at 0x%08h, expected none", bus_addr);
                    end else begin
                        be = bus_q.pop_front();
                        checkOutput("bus_addr", bus_addr, be.baddr);
                        checkOutput("bus_wen", {31'h0, bus_wen}, {31'h0, be.wen});
                        checkOutput("bus_wstrb", {28'h0, bus_wstrb}, {28'h0, be.strb});
                        if (be.wen) checkOutput("bus_wdata", bus_wdata, be.wd);
                    end
                end
            end
            pv = bus_req_valid;
            pr = bus_req_ready;
            pa = bus_addr;
            pw = bus_wdata;
            ps = bus_wstrb;
        end
    end

    // Result monitor: compares each completed instruction with the scoreboard.
    initial begin
        res_exp_t    re;
        logic        pvalid = 1'b0;
        logic        pnr = 1'b1;
        logic [31:0] pres = 32'h0;
        int          rise_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (this_valid && !pvalid) rise_cyc = cyc;
                if (pvalid && !pnr && this_valid)
                    checkOutput("result_stable", result, pres);
                if (this_valid && next_ready) begin
                    if (res_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_valid: got result 0x%08h, expected none", result);
                    end else begin
                        re = res_q.pop_front();
                        checkOutput("result", result, re.res);
                        checkOutput("is_load", {31'h0, is_load}, {31'h0, re.ld});
                        checkOutput("access_err", {31'h0, access_err}, {31'h0, re.err});
                        checkOutput("latency", rise_cyc - re.acc_cyc, re.lat);
                    end
                end
            end
            pvalid = this_valid;
            pnr    = next_ready;
            pres   = result;
        end
    end

    // Issue one instruction, queue its expectations, then wait for it to drain.
    task automatic applyStimulus(
        input logic mreq, input logic wen, input logic [2:0] f3,
        input logic [31:0] a, input logic [31:0] wd,
        input logic [31:0] exp_res, input logic exp_ld, input logic exp_err,
        input int exp_lat, input logic has_bus,
        input logic [3:0] exp_strb, input logic [31:0] exp_wd,
        input int rstall, input int rdly, input int nstall);
        bus_exp_t be;
        res_exp_t re;
        bit       accepted;
        @(posedge clk);
        #2;
        req_cnt   = rstall;
        rsp_delay = rdly;
        nr_cnt    = nstall;
        if (has_bus) begin
            be.baddr = {a[31:2], 2'b00};
            be.wen   = wen;
            be.strb  = exp_strb;
            be.wd    = exp_wd;
            bus_q.push_back(be);
        end
        prev_valid = 1'b1;
        mem_req    = mreq;
        mem_wen    = wen;
        funct3     = f3;
        addr       = a;
        wdata      = wd;
        accepted   = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (this_ready) accepted = 1'b1;
        end
        if (!accepted) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: got this_ready=0, expected 1");
            prev_valid = 1'b0;
            bus_q.delete();
            return;
        end
        re.res     = exp_res;
        re.ld      = exp_ld;
        re.err     = exp_err;
        re.lat     = exp_lat;
        re.acc_cyc = cyc;
        res_q.push_back(re);
        @(posedge clk);
        #2;
        prev_valid = 1'b0;
        funct3     = 3'b111;
        addr       = 32'hFFFF_FFFF;
        wdata      = 32'h0;
        for (int i = 0; i < 60 && res_q.size() != 0; i++) @(negedge clk);
        if (res_q.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL complete_timeout: got %0d pending results, expected 0", res_q.size());
            res_q.delete();
            bus_q.delete();
        end
    endtask

    initial begin
        bit seen;
        bus_exp_t be;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_this_ready", {31'h0, this_ready}, 32'h1);
        checkOutput("rst_this_valid", {31'h0, this_valid}, 32'h0);
        checkOutput("rst_bus_req_valid", {31'h0, bus_req_valid}, 32'h0);
        checkOutput("rst_bus_rsp_ready", {31'h0, bus_rsp_ready}, 32'h0);
        checkOutput("rst_result", result, 32'h0);
        checkOutput("rst_is_load", {31'h0, is_load}, 32'h0);
        checkOutput("rst_access_err", {31'h0, access_err}, 32'h0);
        checkOutput("rst_bus_addr", bus_addr, 32'h0);
        checkOutput("rst_bus_wen", {31'h0, bus_wen}, 32'h0);
        checkOutput("rst_bus_wstrb", {28'h0, bus_wstrb}, 32'h0);
        checkOutput("rst_bus_wdata", bus_wdata, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;

        // Pass-through.
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 1, 1'b0, 4'h0, 32'h0, 0, 0, 0);
        // Loads from word 0x8070_F0FF at 0x100.
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'hFFFF_FFF0, 1'b1, 1'b0, 3, 1'b1, 4'h0, 32'h0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 32'h0000_00F0, 1'b1, 1'b0, 3, 1'b1, 4'h0, 32'h0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF_8070, 1'b1, 1'b0, 3, 1'b1, 4'h0, 32'h0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h0000_8070, 1'b1, 1'b0, 3, 1'b1, 4'h0, 32'h0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h8070_F0FF, 1'b1, 1'b0, 3, 1'b1, 4'h0, 32'h0, 0, 0, 0);
        // Stores; the result is the captured address.
        applyStimulus(1'b1, 1'b1, 3'b000, 32'h203, 32'hAABB_CCDD, 32'h203, 1'b0, 1'b0, 3, 1'b1, 4'b1000, 32'hDDDD_DDDD, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 3'b001, 32'h202, 32'hAABB_CCDD, 32'h202, 1'b0, 1'b0, 3, 1'b1, 4'b1100, 32'hCCDD_CCDD, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h200, 32'hAABB_CCDD, 32'h200, 1'b0, 1'b0, 3, 1'b1, 4'b1111, 32'hAABB_CCDD, 0, 0, 0);
        // Errors: no bus request, flagged one cycle after accept.
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h102, 1'b0, 1'b1, 1, 1'b0, 4'h0, 32'h0, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 3'b001, 32'h201, 32'hAABB_CCDD, 32'h201, 1'b0, 1'b1, 1, 1'b0, 4'h0, 32'h0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h100, 1'b0, 1'b1, 1, 1'b0, 4'h0, 32'h0, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 3'b100, 32'h200, 32'hAABB_CCDD, 32'h200, 1'b0, 1'b1, 1, 1'b0, 4'h0, 32'h0, 0, 0, 0);
        // Backpressure on every channel: 3 + 3 + 2 = 8 cycles to this_valid.
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h8070_F0FF, 1'b1, 1'b0, 8, 1'b1, 4'h0, 32'h0, 3, 2, 2);
        applyStimulus(1'b1, 1'b1, 3'b000, 32'h201, 32'h0000_0077, 32'h201, 1'b0, 1'b0, 5, 1'b1, 4'b0010, 32'h7777_7777, 2, 0, 1);

        // Reset while waiting for a response.
        @(posedge clk);
        #2;
        req_cnt   = 0;
        rsp_delay = 10;
        nr_cnt    = 0;
        be.baddr  = 32'h100;
        be.wen    = 1'b0;
        be.strb   = 4'h0;
        be.wd     = 32'h0;
        bus_q.push_back(be);
        prev_valid = 1'b1;
        mem_req    = 1'b1;
        mem_wen    = 1'b0;
        funct3     = 3'b010;
        addr       = 32'h100;
        @(negedge clk);
        @(posedge clk);
        #2;
        prev_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus_rsp_ready) seen = 1'b1;
        end
        checkOutput("reach_wait", {31'h0, seen}, 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rstw_this_ready", {31'h0, this_ready}, 32'h1);
        checkOutput("rstw_bus_req_valid", {31'h0, bus_req_valid}, 32'h0);
        checkOutput("rstw_bus_rsp_ready", {31'h0, bus_rsp_ready}, 32'h0);
        checkOutput("rstw_this_valid", {31'h0, this_valid}, 32'h0);
        checkOutput("rstw_bus_q_empty", bus_q.size(), 32'h0);
        bus_q.delete();

        applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h8070_F0FF, 1'b1, 1'b0, 3, 1'b1, 4'h0, 32'h0, 0, 0, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
